// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision floating-point ALU.
package fp_pkg;

   localparam int EXP_W    = 8;
   localparam int FRAC_W   = 23;
   localparam int MANT_W   = 24;
   localparam int EXP_BIAS = 127;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } fp_op_e;

endpackage

// File: rtl/fp_div_core.sv
// Combinational restoring divider for normalized 24-bit mantissas.
// Returns floor(dividend * 2^25 / divisor) plus a sticky bit for the remainder.
module fp_div_core (
   input  logic [23:0] dividend_i,
   input  logic [23:0] divisor_i,
   output logic [25:0] quotient_o,
   output logic        sticky_o
);

   logic [25:0] rem;
   logic [25:0] dvs;

   // One quotient bit per step, MSB (integer bit) first.
   always_comb begin
      dvs        = {2'b00, divisor_i};
      rem        = {2'b00, dividend_i};
      quotient_o = '0;
      for (int unsigned i = 0; i < 26; i++) begin
         if (rem >= dvs) begin
            quotient_o[25 - i] = 1'b1;
            rem                = rem - dvs;
         end
         rem = rem << 1;
      end
      sticky_o = |rem;
   end

endmodule

// File: rtl/fp_alu.sv
// Single-cycle binary32 add/sub/mul/div with registered result and flags.
// Flush-to-zero on denormals, round-to-nearest-even.
module fp_alu
   import fp_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [1:0]  operation,
   output logic [31:0] Result,
   output logic        Exception,
   output logic        Overflow,
   output logic        Underflow
);

   fp_op_e      op;
   logic        sA, sB, sBe;
   logic [7:0]  eA, eB;
   logic [23:0] mA, mB;
   logic        zA, zB, iA, iB, nA, nB;

   assign op  = fp_op_e'(operation);
   assign sA  = A[31];
   assign sB  = B[31];
   assign sBe = sB ^ (op == OP_SUB);
   assign eA  = A[30:23];
   assign eB  = B[30:23];
   assign zA  = (eA == 8'h00);
   assign zB  = (eB == 8'h00);
   assign iA  = (eA == 8'hFF) && (A[22:0] == '0);
   assign iB  = (eB == 8'hFF) && (B[22:0] == '0);
   assign nA  = (eA == 8'hFF) && (A[22:0] != '0);
   assign nB  = (eB == 8'hFF) && (B[22:0] != '0);
   assign mA  = zA ? '0 : {1'b1, A[22:0]};
   assign mB  = zB ? '0 : {1'b1, B[22:0]};

   // ---------------- add / subtract path ----------------
   logic        swap, s_big, s_small;
   logic [7:0]  e_big, e_small, e_diff;
   logic [23:0] m_big, m_small;
   logic [5:0]  shamt;
   logic [49:0] align;
   logic [27:0] sum;
   logic [26:0] norm;
   logic [4:0]  lz;
   logic        lz_found;
   logic [23:0] add_man;
   logic        add_g, add_rs;
   logic [10:0] add_exp;

   // Magnitude-ordered alignment, mantissa add/sub and normalization.
   always_comb begin
      swap    = {eB, mB} > {eA, mA};
      s_big   = swap ? sBe : sA;
      s_small = swap ? sA  : sBe;
      e_big   = swap ? eB  : eA;
      e_small = swap ? eA  : eB;
      m_big   = swap ? mB  : mA;
      m_small = swap ? mA  : mB;
      e_diff  = e_big - e_small;
      // Beyond 49 the smaller operand only ever contributes to sticky.
      shamt   = (e_diff > 8'd49) ? 6'd49 : e_diff[5:0];
      align   = {m_small, 26'b0} >> shamt;
      if (s_big == s_small)
         sum = {1'b0, m_big, 3'b000} + {1'b0, align[49:24], |align[23:0]};
      else
         sum = {1'b0, m_big, 3'b000} - {1'b0, align[49:24], |align[23:0]};
      lz       = '0;
      lz_found = 1'b0;
      for (int unsigned i = 0; i < 27; i++) begin
         if (!lz_found && sum[26 - i]) begin
            lz       = 5'(i);
            lz_found = 1'b1;
         end
      end
      norm = sum[26:0] << lz;
      if (sum[27]) begin
         add_man = sum[27:4];
         add_g   = sum[3];
         add_rs  = |sum[2:0];
         add_exp = {3'b000, e_big} + 11'd1;
      end else begin
         add_man = norm[26:3];
         add_g   = norm[2];
         add_rs  = |norm[1:0];
         add_exp = {3'b000, e_big} - {6'b0, lz};
      end
   end

   // ---------------- multiply / divide paths ----------------
   logic [47:0] prod;
   logic [25:0] div_q;
   logic        div_sticky;

   assign prod = mA * mB;

   fp_div_core u_div (
      .dividend_i (mA),
      .divisor_i  (mB),
      .quotient_o (div_q),
      .sticky_o   (div_sticky)
   );

   // ---------------- operation select and special cases ----------------
   logic        r_sign, r_g, r_rs, true_zero, nan_res, inf_res, inf_sign;
   logic [23:0] r_man;
   logic [10:0] r_exp;

   // Pick the pre-rounding result and classify special operands.
   always_comb begin
      r_sign    = sA ^ sB;
      r_man     = '0;
      r_g       = 1'b0;
      r_rs      = 1'b0;
      r_exp     = '0;
      true_zero = 1'b0;
      nan_res   = nA | nB;
      inf_res   = iA | iB;
      inf_sign  = sA ^ sB;
      unique case (op)
         OP_ADD, OP_SUB: begin
            r_sign    = s_big;
            r_man     = add_man;
            r_g       = add_g;
            r_rs      = add_rs;
            r_exp     = add_exp;
            true_zero = (sum == '0);
            nan_res   = nA | nB | (iA & iB & (sA != sBe));
            inf_sign  = iA ? sA : sBe;
         end
         OP_MUL: begin
            if (prod[47]) begin
               r_man = prod[47:24];
               r_g   = prod[23];
               r_rs  = |prod[22:0];
            end else begin
               r_man = prod[46:23];
               r_g   = prod[22];
               r_rs  = |prod[21:0];
            end
            r_exp     = {3'b000, eA} + {3'b000, eB} - 11'(EXP_BIAS) + {10'b0, prod[47]};
            true_zero = zA | zB;
            nan_res   = nA | nB | (iA & zB) | (zA & iB);
         end
         default: begin
            // Quotient < 1.0 leaves only a guard bit; the remainder covers round|sticky.
            if (div_q[25]) begin
               r_man = div_q[25:2];
               r_g   = div_q[1];
               r_rs  = div_q[0] | div_sticky;
            end else begin
               r_man = div_q[24:1];
               r_g   = div_q[0];
               r_rs  = div_sticky;
            end
            r_exp     = {3'b000, eA} - {3'b000, eB} + 11'(EXP_BIAS) - {10'b0, ~div_q[25]};
            true_zero = zA;
            nan_res   = nA | nB | zB | (iA & iB);
         end
      endcase
   end

   // ---------------- rounding, range check and packing ----------------
   logic        rnd_inc;
   logic [24:0] m_rnd;
   logic [23:0] man_f;
   logic [10:0] exp_f;
   logic [31:0] result_d, result_q;
   logic        exc_d, ovf_d, unf_d, exc_q, ovf_q, unf_q;

   // RNE rounding then final classification in priority order.
   always_comb begin
      rnd_inc = r_g & (r_rs | r_man[0]);
      m_rnd   = {1'b0, r_man} + {24'b0, rnd_inc};
      if (m_rnd[24]) begin
         man_f = m_rnd[24:1];
         exp_f = r_exp + 11'd1;
      end else begin
         man_f = m_rnd[23:0];
         exp_f = r_exp;
      end
      exc_d = 1'b0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
      if (nan_res) begin
         result_d = QNAN;
         exc_d    = 1'b1;
      end else if (inf_res) begin
         result_d = POS_INF | {inf_sign, 31'b0};
         exc_d    = 1'b1;
      end else if (true_zero) begin
         result_d = (op == OP_ADD || op == OP_SUB) ? '0 : {r_sign, 31'b0};
      end else if (!exp_f[10] && exp_f >= 11'd255) begin
         result_d = POS_INF | {r_sign, 31'b0};
         ovf_d    = 1'b1;
      end else if (exp_f[10] || exp_f == '0) begin
         result_d = {r_sign, 31'b0};
         unf_d    = 1'b1;
      end else begin
         result_d = {r_sign, exp_f[7:0], man_f[22:0]};
      end
   end

   // Output register; reset clears result and flags immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_q <= '0;
         exc_q    <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         result_q <= result_d;
         exc_q    <= exc_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   assign Result    = result_q;
   assign Exception = exc_q;
   assign Overflow  = ovf_q;
   assign Underflow = unf_q;

endmodule

// File: tb/tb_fp_alu.sv
// Scoreboard bench for fp_alu: driver pushes expected responses, monitor pops and compares.
module tb_fp_alu;

   logic        clk;
   logic        rst;
   logic [31:0] A, B;
   logic [1:0]  operation;
   logic [31:0] Result;
   logic        Exception, Overflow, Underflow;

   typedef struct {
      string       name;
      logic [31:0] res;
      logic        e, o, u;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   fp_alu dut (
      .clk       (clk),
      .rst       (rst),
      .A         (A),
      .B         (B),
      .operation (operation),
      .Result    (Result),
      .Exception (Exception),
      .Overflow  (Overflow),
      .Underflow (Underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, input logic [31:0] res,
                        input logic e, input logic o, input logic u);
      exp_t x;
      @(negedge clk);
      A = a;
      B = b;
      operation = op;
      x.name = name; x.res = res; x.e = e; x.o = o; x.u = u;
      sb.push_back(x);
   endtask

   task automatic check_now(input string name, input logic [31:0] res,
                            input logic e, input logic o, input logic u);
      n_vec++;
      if ({Result, Exception, Overflow, Underflow} !== {res, e, o, u}) begin
         n_err++;
         $display("FAIL %s: got %h E%b O%b U%b, required %h E%b O%b U%b",
                  name, Result, Exception, Overflow, Underflow, res, e, o, u);
      end
   endtask

   // Monitor: one result per edge whenever a response is outstanding.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (!rst && sb.size() > 0) begin
            x = sb.pop_front();
            check_now(x.name, x.res, x.e, x.o, x.u);
         end
      end
   end

   initial begin
      bit drained;
      rst = 1'b0;
      A = '0;
      B = '0;
      operation = 2'b00;
      #2 rst = 1'b1;
      #1 check_now("reset_state", 32'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      issue("add_9.8_4.3",   32'h411CCCCD, 32'h4089999A, 2'b00, 32'h4161999A, 0, 0, 0);
      issue("sub_9.8_4.3",   32'h411CCCCD, 32'h4089999A, 2'b01, 32'h40B00000, 0, 0, 0);
      issue("mul_9.8_4.3",   32'h411CCCCD, 32'h4089999A, 2'b10, 32'h42288F5D, 0, 0, 0);
      issue("div_9.8_4.3",   32'h411CCCCD, 32'h4089999A, 2'b11, 32'h4011DC47, 0, 0, 0);
      issue("mul_ovf",       32'h7F000000, 32'h7F000000, 2'b10, 32'h7F800000, 0, 1, 0);
      issue("add_ovf",       32'h7F000000, 32'h7F000000, 2'b00, 32'h7F800000, 0, 1, 0);
      issue("mul_unf",       32'h00800000, 32'h00800000, 2'b10, 32'h00000000, 0, 0, 1);
      issue("sub_exact0",    32'h3F800000, 32'h3F800000, 2'b01, 32'h00000000, 0, 0, 0);
      issue("div_by_zero",   32'h3F800000, 32'h00000000, 2'b11, 32'h7FC00000, 1, 0, 0);
      issue("nan_add",       32'h7FC00000, 32'h3F800000, 2'b00, 32'h7FC00000, 1, 0, 0);
      issue("nan_sub",       32'h7FC00000, 32'h40000000, 2'b01, 32'h7FC00000, 1, 0, 0);
      issue("nan_mul",       32'h7FC00000, 32'h00000000, 2'b10, 32'h7FC00000, 1, 0, 0);
      issue("nan_div",       32'h7FC00000, 32'hC0400000, 2'b11, 32'h7FC00000, 1, 0, 0);
      issue("add_1_1",       32'h3F800000, 32'h3F800000, 2'b00, 32'h40000000, 0, 0, 0);
      issue("mul_2_3",       32'h40000000, 32'h40400000, 2'b10, 32'h40C00000, 0, 0, 0);
      issue("mul_m2_3",      32'hC0000000, 32'h40400000, 2'b10, 32'hC0C00000, 0, 0, 0);
      issue("div_1_3",       32'h3F800000, 32'h40400000, 2'b11, 32'h3EAAAAAB, 0, 0, 0);
      issue("add_tie_even",  32'h3F800000, 32'h33800000, 2'b00, 32'h3F800000, 0, 0, 0);
      issue("add_tie_up",    32'h3F800000, 32'h33800001, 2'b00, 32'h3F800001, 0, 0, 0);
      issue("inf_plus_1",    32'h7F800000, 32'h3F800000, 2'b00, 32'h7F800000, 1, 0, 0);
      issue("inf_minus_inf", 32'h7F800000, 32'h7F800000, 2'b01, 32'h7FC00000, 1, 0, 0);
      issue("zero_x_inf",    32'h00000000, 32'h7F800000, 2'b10, 32'h7FC00000, 1, 0, 0);
      issue("zero_div_zero", 32'h00000000, 32'h00000000, 2'b11, 32'h7FC00000, 1, 0, 0);

      issue("pre_reset_add", 32'h411CCCCD, 32'h4089999A, 2'b00, 32'h4161999A, 0, 0, 0);
      drained = 1'b0;
      for (int i = 0; i < 20 && !drained; i++) begin
         @(negedge clk);
         if (sb.size() == 0) drained = 1'b1;
      end
      if (!drained) begin
         n_vec++;
         n_err++;
         $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
         sb.delete();
      end

      // Assert reset between edges while Result is nonzero.
      @(posedge clk);
      #3 rst = 1'b1;
      #1 check_now("async_reset", 32'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1 check_now("held_after_release", 32'h0, 1'b0, 1'b0, 1'b0);
      issue("post_reset_sub", 32'h411CCCCD, 32'h4089999A, 2'b01, 32'h40B00000, 0, 0, 0);

      drained = 1'b0;
      for (int i = 0; i < 20 && !drained; i++) begin
         @(negedge clk);
         if (sb.size() == 0) drained = 1'b1;
      end
      if (!drained) begin
         n_vec++;
         n_err++;
         $display("FAIL final_drain: %0d responses outstanding, required 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
